// File: rtl/spi_pkg.sv
// Shared SPI frame definitions, used by both the controller and the peripheral side.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_BITS  = 7;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned RW_BIT     = 15;
  localparam int unsigned MAX_ADDR   = 4;

  // Width of the bit counter (counts 0..FRAME_BITS-1) and of the phase timer.
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int unsigned TICK_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // On-wire frame layout, MSB transmitted first.
  typedef struct packed {
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } spi_frame_t;

  // True when the address is beyond the peripheral's register map.
  function automatic logic addr_out_of_range(input logic [ADDR_BITS-1:0] addr);
    return addr > ADDR_BITS'(MAX_ADDR);
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer: reloads on every state change and flags the last cycle of the phase.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int unsigned W = TICK_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick_c
);

  logic [W-1:0] cnt;

  // Down-counter: load with (phase length - 1), then count to zero and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Counter at zero marks the final cycle of the current phase.
  assign tick_c = (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 frame transmitter: one 16-bit {rw, addr, data} frame per accepted request.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_data,
  output logic                 done,
  output logic                 addr_err,
  output logic                 SCLK,
  output logic                 nCS,
  output logic                 COPI
);

  localparam logic [TICK_W-1:0] HALF_LOAD = TICK_W'(HALF_PERIOD - 1);
  localparam logic [TICK_W-1:0] GAP_LOAD  = TICK_W'(GAP_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  spi_state_e            state;
  spi_state_e            state_next;
  logic [FRAME_BITS-1:0] shreg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  err_flag;
  logic                  done_pend;

  spi_frame_t            frame_c;
  logic                  accept_c;
  logic                  shift_c;
  logic                  done_set_c;
  logic                  tick_c;
  logic                  load_c;
  logic [TICK_W-1:0]     load_val_c;

  logic                  ncs_d;
  logic                  sclk_d;
  logic                  copi_d;
  logic                  ready_d;

  assign frame_c    = '{rw: req_rw, addr: req_addr, data: req_data};
  assign accept_c   = req_valid && req_ready;
  assign load_c     = (state_next != state);
  assign load_val_c = (state_next == ST_GAP) ? GAP_LOAD : HALF_LOAD;

  spi_tick_gen #(
    .W (TICK_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (load_val_c),
    .tick_c   (tick_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and pin values decoded from the current state.
  always_comb begin
    state_next = state;
    shift_c    = 1'b0;
    done_set_c = 1'b0;
    ncs_d      = 1'b1;
    sclk_d     = 1'b0;
    copi_d     = 1'b0;
    ready_d    = 1'b0;

    case (state)
      ST_IDLE: begin
        ready_d = !accept_c;
        if (accept_c) begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        ncs_d  = 1'b0;
        copi_d = shreg[RW_BIT];
        if (tick_c) begin
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        ncs_d  = 1'b0;
        sclk_d = 1'b1;
        copi_d = shreg[RW_BIT];
        if (tick_c) begin
          if (bit_cnt == LAST_BIT) begin
            state_next = ST_HOLD;
          end else begin
            state_next = ST_LOW;
            shift_c    = 1'b1;
          end
        end
      end
      ST_LOW: begin
        ncs_d  = 1'b0;
        copi_d = shreg[RW_BIT];
        if (tick_c) begin
          state_next = ST_HIGH;
        end
      end
      ST_HOLD: begin
        ncs_d = 1'b0;
        if (tick_c) begin
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick_c) begin
          state_next = ST_IDLE;
          done_set_c = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Frame capture on acceptance; shift toward the MSB on each falling SCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (accept_c) begin
      shreg    <= frame_c;
      bit_cnt  <= '0;
      err_flag <= addr_out_of_range(req_addr);
    end else if (shift_c) begin
      shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
      bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  // Output registers; done is held one extra cycle so it lands with req_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nCS       <= 1'b1;
      SCLK      <= 1'b0;
      COPI      <= 1'b0;
      req_ready <= 1'b0;
      done_pend <= 1'b0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      nCS       <= ncs_d;
      SCLK      <= sclk_d;
      COPI      <= copi_d;
      req_ready <= ready_d;
      done_pend <= done_set_c;
      done      <= done_pend;
      addr_err  <= done_pend && err_flag;
    end
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter HALF_PERIOD, default 4: clk cycles per SCLK half-period; legal range 4..255.
REQ-002 Parameter GAP_CYCLES, default 8: clk cycles nCS is held high after a frame before the next frame may start; legal range 4..255.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  host request to send one frame.
REQ-006 req_ready  output  1  controller idle and able to accept a request.
REQ-007 req_rw  input  1  frame R/W bit; 1 = write (committed by peripheral), 0 = no-commit frame.
REQ-008 req_addr  input  7  register address.
REQ-009 req_data  input  8  register data.
REQ-010 done  output  1  one-cycle pulse at frame completion.
REQ-011 addr_err  output  1  one-cycle pulse coincident with done when the sent address > MAX_ADDR (4).
REQ-012 SCLK  output  1  serial clock, SPI mode 0 (idle low).
REQ-013 nCS  output  1  active-low chip select.
REQ-014 COPI  output  1  serial data, MSB first.

Function
REQ-015 Frame = 16 bits {req_rw, req_addr[6:0], req_data[7:0]}; bit 15 transmitted first.
REQ-016 Request accepted on a clk edge where req_valid && req_ready; rw/addr/data captured into a 16-bit shift register on that edge; later input changes have no effect.
REQ-017 req_ready = 1 only in IDLE; req_valid while busy is ignored, not queued.
REQ-018 States: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
REQ-019 IDLE: nCS=1, SCLK=0, COPI=0; on acceptance -> SETUP.
REQ-020 SETUP: nCS=0, SCLK=0, COPI=frame bit 15; HALF_PERIOD cycles -> HIGH.
REQ-021 HIGH: SCLK=1, COPI stable; HALF_PERIOD cycles; after the 16th HIGH -> HOLD, else -> LOW.
REQ-022 LOW: SCLK=0; COPI advances to next bit on entry (falling edge); HALF_PERIOD cycles -> HIGH.
REQ-023 HOLD: SCLK=0, nCS=0, COPI=0; HALF_PERIOD cycles -> GAP.
REQ-024 GAP: nCS=1, SCLK=0; GAP_CYCLES cycles -> IDLE, asserting done (and addr_err if applicable) on the IDLE-entry cycle, together with req_ready.
REQ-025 Timing, acceptance at edge T0, H=HALF_PERIOD, G=GAP_CYCLES: nCS falls at T0+1; first SCLK rise at T0+1+H; exactly 16 SCLK rising edges; nCS rises at T0+1+33H; done/req_ready at T0+1+33H+G.
REQ-026 All of SCLK, nCS, COPI, done, addr_err, req_ready are registered outputs; no glitches.
REQ-027 New request accepted in the same cycle req_ready rises (back-to-back), giving nCS high exactly G cycles between frames.
REQ-028 Frames with req_rw=0 are transmitted identically; done still pulses.
REQ-029 addr_err does not suppress transmission.

Reset
REQ-030 rst_n low: immediately nCS=1, SCLK=0, COPI=0, done=0, addr_err=0, state=IDLE, counters and shift register 0.
REQ-031 Reset mid-frame aborts the frame with no done pulse; req_ready=1 on the first clk edge after rst_n deasserts.

Structure
REQ-032 Shared package spi_pkg holds FRAME_BITS=16, ADDR_BITS=7, DATA_BITS=8, RW_BIT=15, MAX_ADDR=4 and the state enum; shared with the peripheral side.
REQ-033 One sub-module spi_tick_gen: down-counter reloaded on state change, pulsing when a phase of HALF_PERIOD or GAP_CYCLES expires.

Verification
REQ-034 Write addr 0, data 0xA5, H=4: COPI bits on SCLK rises = 1,0000000,10100101; nCS low at T0+1, high at T0+133; done at T0+141; looped peripheral en_reg_out_7_0 = 0xA5.
REQ-035 Back-to-back writes addr 4 = 0x80 then addr 2 = 0x0F: nCS high exactly 8 cycles between frames; peripheral pwm_duty_cycle=0x80, en_reg_pwm_7_0=0x0F.
REQ-036 Write addr 5, data 0xFF: full frame sent, done and addr_err pulse together; no peripheral register changes.
REQ-037 rw=0 to addr 1, data 0x3C: 16 rises observed, done pulses; en_reg_out_15_8 unchanged.
REQ-038 rst_n pulsed after the 9th SCLK rise: nCS=1, SCLK=0 immediately; no done; next frame to addr 3 = 0x55 completes correctly.
REQ-039 req_valid held high with changing data during a frame: only the captured frame is sent; the next accepted frame is the one presented when req_ready=1.
